bus_err_drain_arb: RTL
======================

Name: bus_err_drain_arb

Overview:
- Round-robin arbiter that drains the error FIFOs of NumSrc bare bus error units into one shared error-record stream.
- Feeds a single reporting sink: a register file, a DMA logger or a debug module.
- Pops exactly one record from the granted source per grant.
- Tags each record with its source index, raises an aggregate interrupt and counts forwarded records.

Parameters:
- NumSrc, 4, number of bus error units drained (>=2)
- AddrWidth, 48, error address width
- MetaDataWidth, 1, metadata width
- ErrBits, 3, error code width
- CntWidth, 16, forwarded-record counter width
- IdxWidth, derived $clog2(NumSrc), source index width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- enable_i  in  1  permit new grants
- src_mask_i  in  NumSrc  1 = source excluded from arbitration
- src_valid_i  in  NumSrc  source FIFO non-empty; head fields valid
- src_addr_i  in  NumSrc*AddrWidth  head address per source, source i at [i*AddrWidth +: AddrWidth]
- src_meta_i  in  NumSrc*MetaDataWidth  head metadata per source
- src_err_i  in  NumSrc*ErrBits  head error code per source
- src_overflow_i  in  NumSrc  source FIFO overflow flag
- src_pop_o  out  NumSrc  one-hot pop strobe, one cycle
- out_valid_o  out  1  record valid
- out_ready_i  in  1  sink accepts record
- out_src_o  out  IdxWidth  source index of record
- out_addr_o  out  AddrWidth  record address
- out_meta_o  out  MetaDataWidth  record metadata
- out_err_o  out  ErrBits  record error code
- out_overflow_o  out  1  overflow flag captured with record
- irq_o  out  1  aggregate error interrupt
- cnt_clr_i  in  1  synchronous clear of fwd_cnt_o
- fwd_cnt_o  out  CntWidth  saturating count of accepted records

Behaviour:
- Reset values:
  - out_valid_o=0, src_pop_o=0, irq_o=0, fwd_cnt_o=0.
  - All out_* data fields 0.
  - Round-robin pointer 0; FSM in IDLE.
- Eligible set: src_valid_i & ~src_mask_i.
- Grant condition: grant_ok = enable_i & (|eligible) & (state==IDLE | (state==FULL & out_ready_i)).
- On grant_ok:
  - Winner = first eligible index at or after the pointer, wrapping modulo NumSrc.
  - src_pop_o[winner]=1 combinationally in the same cycle.
  - Winner's head fields and index are registered into the output register.
  - Pointer <= (winner+1) mod NumSrc.
- Pointer does not change without a grant.
- FSM:
  - IDLE -> FULL on grant_ok.
  - FULL stays FULL while out_ready_i=0.
  - FULL with out_ready_i=1: re-grant same cycle and stay FULL (back-to-back, one record/cycle sustained); otherwise go to IDLE.
- out_valid_o = (state==FULL). Output fields are stable while out_valid_o=1 and out_ready_i=0.
- Latency: source valid to out_valid_o is 1 cycle.
- src_pop_o is at most one-hot and is never asserted for a masked or invalid source.
- enable_i=0:
  - No new grants.
  - A pending record remains valid until accepted, then the FSM goes to IDLE.
- Masking a source while its record sits in the output register does not cancel that record.
- irq_o is registered: next value = (|eligible) | out_valid_next. It is deasserted one cycle after all work drains.
- fwd_cnt_o:
  - Increments on out_valid_o & out_ready_i.
  - Saturates at 2^CntWidth-1.
  - cnt_clr_i wins over a simultaneous increment (result 0).
- Reset asserted mid-operation: everything returns to reset values immediately. The in-flight record is lost; the source FIFO already popped it.

Optional Feature:
- Macro: BUS_ERR_DRAIN_ARB_OVF_PRIO_EN.
- Defined: eligible sources with src_overflow_i=1 form a priority class that is round-robin arbitrated with the shared pointer. Sources without overflow are granted only when no overflowing eligible source exists.
- Undefined: src_overflow_i only feeds out_overflow_o; pure round-robin.

Test Plan:
- Reset, then src_valid_i=4'b0100, addr[2]=0x1234, ready=1 -> cycle+0 src_pop_o=4'b0100; cycle+1 out_valid_o=1, out_src_o=2, out_addr_o=0x1234, irq_o=1; fwd_cnt_o=1 after handshake.
- All four sources valid continuously, ready=1, pointer 0 -> grants 0,1,2,3,0 on consecutive cycles, one pop per cycle, fwd_cnt_o=+1 per cycle.
- Source 1 valid, ready=0 for 5 cycles -> single pop, out fields constant 5 cycles, no further pops; ready=1 -> accepted, FSM to IDLE if nothing eligible.
- src_mask_i=4'b0011, all valid -> only 2 and 3 ever granted; enable_i=0 mid-stream -> the pending record completes, then no pops, irq_o stays 1 while eligible sources remain.
- CntWidth=2: accept 5 records -> fwd_cnt_o saturates at 3; cnt_clr_i with a concurrent handshake -> 0.
- With BUS_ERR_DRAIN_ARB_OVF_PRIO_EN defined: sources 0 and 3 valid, overflow only on 3, pointer 0 -> source 3 granted first; without the macro -> source 0 first.

Source files
------------

// File: rtl/bus_err_drain_arb.sv
// Round-robin drain of NumSrc bus-error FIFOs into one tagged record stream.
// Optional overflow-priority class enabled with `define BUS_ERR_DRAIN_ARB_OVF_PRIO_EN.
module bus_err_drain_arb #(
    parameter int NumSrc        = 4,
    parameter int AddrWidth     = 48,
    parameter int MetaDataWidth = 1,
    parameter int ErrBits       = 3,
    parameter int CntWidth      = 16,
    parameter int IdxWidth      = $clog2(NumSrc)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              enable_i,
    input  logic [NumSrc-1:0]                 src_mask_i,
    input  logic [NumSrc-1:0]                 src_valid_i,
    input  logic [NumSrc*AddrWidth-1:0]       src_addr_i,
    input  logic [NumSrc*MetaDataWidth-1:0]   src_meta_i,
    input  logic [NumSrc*ErrBits-1:0]         src_err_i,
    input  logic [NumSrc-1:0]                 src_overflow_i,
    output logic [NumSrc-1:0]                 src_pop_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [IdxWidth-1:0]               out_src_o,
    output logic [AddrWidth-1:0]              out_addr_o,
    output logic [MetaDataWidth-1:0]          out_meta_o,
    output logic [ErrBits-1:0]                out_err_o,
    output logic                              out_overflow_o,
    output logic                              irq_o,
    input  logic                              cnt_clr_i,
    output logic [CntWidth-1:0]               fwd_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_next, win_idx;
    logic [NumSrc-1:0]   eligible, cand;
    logic                win_found, grant_ok;

    assign eligible = src_valid_i & ~src_mask_i;

`ifdef BUS_ERR_DRAIN_ARB_OVF_PRIO_EN
    logic [NumSrc-1:0] ovf_eligible;
    assign ovf_eligible = eligible & src_overflow_i;
    assign cand         = (|ovf_eligible) ? ovf_eligible : eligible;
`else
    assign cand = eligible;
`endif

    // Search starts at the pointer and wraps, so the last winner gets lowest priority.
    always_comb begin : rr_pick
        logic [IdxWidth-1:0] idx;
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        win_idx   = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int i = 0; i < NumSrc; i++) begin
            idx = IdxWidth'((int'(rr_ptr_q) + i) % NumSrc);
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    assign rr_ptr_next = (win_idx == IdxWidth'(NumSrc - 1)) ? '0 : win_idx + 1'b1;
    assign grant_ok    = enable_i & win_found &
                         ((state_q == IDLE) | ((state_q == FULL) & out_ready_i));
    assign src_pop_o   = grant_ok ? (NumSrc'(1) << win_idx) : '0;
    assign out_valid_o = (state_q == FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_ok) state_d = FULL;
            FULL:    if (out_ready_i && !grant_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            out_src_o      <= '0;
            out_addr_o     <= '0;
            out_meta_o     <= '0;
            out_err_o      <= '0;
            out_overflow_o <= 1'b0;
            irq_o          <= 1'b0;
            fwd_cnt_o      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            irq_o   <= (|eligible) | (state_d == FULL);
            if (grant_ok) begin
                rr_ptr_q       <= rr_ptr_next;
                out_src_o      <= win_idx;
                out_addr_o     <= src_addr_i[int'(win_idx)*AddrWidth +: AddrWidth];
                out_meta_o     <= src_meta_i[int'(win_idx)*MetaDataWidth +: MetaDataWidth];
                out_err_o      <= src_err_i[int'(win_idx)*ErrBits +: ErrBits];
                out_overflow_o <= src_overflow_i[win_idx];
            end
            // Clear takes precedence over a same-cycle handshake.
            if (cnt_clr_i) begin
                fwd_cnt_o <= '0;
            end else if (out_valid_o && out_ready_i && (fwd_cnt_o != {CntWidth{1'b1}})) begin
                fwd_cnt_o <= fwd_cnt_o + 1'b1;
            end
        end
    end

endmodule
